// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory access sequencer: lane decode, request/ready handshake, wait-state timeout
module mem_access_ctrl #(
    parameter int unsigned     WORD     = 16,
    parameter int unsigned     LANES    = WORD / 8,
    parameter logic [WORD-1:0] EXC_RET  = WORD'(16'hFFFF),
    parameter logic [WORD-1:0] PSW_ADDR = WORD'(16'hFFFC),
    parameter int unsigned     TIMEOUT  = 15
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_i,
    input  logic             wr_i,
    input  logic             byteEn_i,
    input  logic [WORD-1:0]  addr_i,
    input  logic [WORD-1:0]  wdata_i,
    output logic             ack_o,
    output logic             fault_o,
    output logic             pswAddr_o,
    output logic             excRet_o,
    output logic [WORD-1:0]  rdata_o,
    output logic             memReq_o,
    output logic             memWr_o,
    output logic [WORD-1:0]  memAddr_o,
    output logic [LANES-1:0] memLanes_o,
    output logic [WORD-1:0]  memWdata_o,
    input  logic [WORD-1:0]  memRdata_i,
    input  logic             memRdy_i
);

    localparam int unsigned LB = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             byte_q, byte_d;
    logic [LB-1:0]    lane_q, lane_d;
    logic             ack_q, ack_d;
    logic             fault_q, fault_d;
    logic             psw_q, psw_d;
    logic             exc_q, exc_d;
    logic [WORD-1:0]  rdata_q, rdata_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_wr_q, mem_wr_d;
    logic [WORD-1:0]  mem_addr_q, mem_addr_d;
    logic [LANES-1:0] mem_lanes_q, mem_lanes_d;
    logic [WORD-1:0]  mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        byte_d      = byte_q;
        lane_d      = lane_q;
        ack_d       = 1'b0;
        fault_d     = 1'b0;
        psw_d       = psw_q;
        exc_d       = exc_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_lanes_d = mem_lanes_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                rdata_d = '0;
                if (req_i) begin
                    wr_d   = wr_i;
                    byte_d = byteEn_i;
                    lane_d = addr_i[LB-1:0];
                    cnt_d  = 8'd0;
                    psw_d  = (addr_i[WORD-1:LB] == PSW_ADDR[WORD-1:LB]);
                    exc_d  = (addr_i == EXC_RET);
                    if (!byteEn_i && (|addr_i[LB-1:0])) begin
                        // Misaligned word access faults without touching memory.
                        state_d = S_FAULT;
                        ack_d   = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = wr_i;
                        mem_addr_d  = {addr_i[WORD-1:LB], {LB{1'b0}}};
                        mem_lanes_d = byteEn_i ? (LANES'(1) << addr_i[LB-1:0]) : {LANES{1'b1}};
                        mem_wdata_d = byteEn_i ? {LANES{wdata_i[7:0]}} : wdata_i;
                    end
                end
            end
            S_ACCESS: begin
                if (memRdy_i || (cnt_q + 8'd1 == 8'(TIMEOUT))) begin
                    mem_req_d   = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_lanes_d = '0;
                    mem_wdata_d = '0;
                    ack_d       = 1'b1;
                end
                // Ready on the timeout cycle still counts as a success.
                if (memRdy_i) begin
                    state_d = S_DONE;
                    if (wr_q) begin
                        rdata_d = '0;
                    end else if (byte_q) begin
                        rdata_d = {{(WORD-8){1'b0}}, memRdata_i[{lane_q, 3'b000} +: 8]};
                    end else begin
                        rdata_d = memRdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_DONE, S_FAULT: begin
                state_d = S_IDLE;
                psw_d   = 1'b0;
                exc_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= '0;
            ack_q       <= 1'b0;
            fault_q     <= 1'b0;
            psw_q       <= 1'b0;
            exc_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_lanes_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            byte_q      <= byte_d;
            lane_q      <= lane_d;
            ack_q       <= ack_d;
            fault_q     <= fault_d;
            psw_q       <= psw_d;
            exc_q       <= exc_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_lanes_q <= mem_lanes_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ack_o      = ack_q;
    assign fault_o    = fault_q;
    assign pswAddr_o  = psw_q;
    assign excRet_o   = exc_q;
    assign rdata_o    = rdata_q;
    assign memReq_o   = mem_req_q;
    assign memWr_o    = mem_wr_q;
    assign memAddr_o  = mem_addr_q;
    assign memLanes_o = mem_lanes_q;
    assign memWdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl (WORD=32, TIMEOUT=4)
module tb_mem_access_ctrl;

    localparam int W   = 32;
    localparam int TMO = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          req_i = 1'b0, wr_i = 1'b0, byteEn_i = 1'b0, memRdy_i = 1'b0;
    logic [W-1:0]  addr_i = '0, wdata_i = '0, memRdata_i = '0;
    logic          ack_o, fault_o, pswAddr_o, excRet_o, memReq_o, memWr_o;
    logic [W-1:0]  rdata_o, memAddr_o, memWdata_o;
    logic [3:0]    memLanes_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.WORD(W), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .wr_i(wr_i),
        .byteEn_i(byteEn_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(ack_o), .fault_o(fault_o), .pswAddr_o(pswAddr_o), .excRet_o(excRet_o),
        .rdata_o(rdata_o), .memReq_o(memReq_o), .memWr_o(memWr_o), .memAddr_o(memAddr_o),
        .memLanes_o(memLanes_o), .memWdata_o(memWdata_o), .memRdata_i(memRdata_i),
        .memRdy_i(memRdy_i)
    );

    typedef struct {
        logic        wr;
        logic        be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          nwait;
        logic [3:0]  lanes;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic        fault;
        logic        psw;
        logic        exc;
        int          ack_cyc;
        int          req_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input logic wr, input logic be, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] mrdata,
                                   input int nwait);
        vec_t v;
        int   lane;
        logic mis, tmo;
        lane      = int'(addr % 32'd4);
        mis       = !be && lane != 0;
        tmo       = !mis && nwait >= TMO;
        v.wr      = wr;
        v.be      = be;
        v.addr    = addr;
        v.wdata   = wdata;
        v.mrdata  = mrdata;
        v.nwait   = nwait;
        v.lanes   = be ? 4'(1 << lane) : 4'hF;
        v.maddr   = addr - 32'(lane);
        v.mwdata  = be ? 32'(wdata[7:0]) * 32'h01010101 : wdata;
        v.psw     = (addr / 32'd4) == (32'hFFFC / 32'd4);
        v.exc     = addr == 32'hFFFF;
        v.fault   = mis || tmo;
        v.ack_cyc = mis ? 1 : (tmo ? TMO + 1 : nwait + 2);
        v.req_cyc = mis ? 0 : (tmo ? TMO : nwait + 1);
        v.rdata   = (v.fault || wr) ? 32'h0 : (be ? (mrdata >> (8 * lane)) & 32'hFF : mrdata);
        return v;
    endfunction

    // Called just after a rising edge with the DUT idle; acts as the memory.
    task automatic run_txn(input vec_t v, input int id);
        int   c, ack_at, req_n, acks;
        logic stable_ok;
        string tag;
        tag       = $sformatf("txn%0d", id);
        ack_at    = -1;
        req_n     = 0;
        acks      = 0;
        stable_ok = 1'b1;
        c         = 0;
        req_i = 1'b1; wr_i = v.wr; byteEn_i = v.be; addr_i = v.addr; wdata_i = v.wdata;
        memRdy_i = 1'b0;
        while (c < 3 * TMO + 8) begin
            @(posedge clk_i);
            #1;
            c++;
            if (memReq_o) begin
                req_n++;
                if (memWr_o !== v.wr || memAddr_o !== v.maddr ||
                    memLanes_o !== v.lanes || memWdata_o !== v.mwdata)
                    stable_ok = 1'b0;
            end
            if (ack_o) begin
                acks++;
                if (ack_at < 0) begin
                    ack_at = c;
                    check({tag, " fault"}, 32'(fault_o), 32'(v.fault));
                    check({tag, " psw"}, 32'(pswAddr_o), 32'(v.psw));
                    check({tag, " exc"}, 32'(excRet_o), 32'(v.exc));
                    check({tag, " rdata"}, rdata_o, v.rdata);
                end
            end
            if (ack_at >= 0 && c == ack_at + 1) break;
            req_i      = (ack_at < 0) ? 1'($urandom) : 1'b0;
            wr_i       = 1'($urandom);
            byteEn_i   = 1'($urandom);
            addr_i     = $urandom;
            wdata_i    = $urandom;
            memRdy_i   = memReq_o ? (c - 1 == v.nwait) : 1'($urandom);
            memRdata_i = memRdy_i && memReq_o ? v.mrdata : $urandom;
        end
        req_i    = 1'b0;
        memRdy_i = 1'b0;
        check({tag, " ack_cycle"}, 32'(ack_at), 32'(v.ack_cyc));
        check({tag, " req_cycles"}, 32'(req_n), 32'(v.req_cyc));
        check({tag, " ack_pulses"}, 32'(acks), 32'd1);
        check({tag, " mem_outputs"}, 32'(stable_ok), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " flags"}, {26'd0, ack_o, fault_o, pswAddr_o, excRet_o, memReq_o, memWr_o}, 32'd0);
        check({name, " lanes"}, 32'(memLanes_o), 32'd0);
        check({name, " rdata"}, rdata_o, 32'd0);
        check({name, " addr_wdata"}, memAddr_o | memWdata_o, 32'd0);
    endtask

    vec_t tbl[11];
    vec_t rv;
    int   acks_rst;

    initial begin
        //        wr    be    addr          wdata         mrdata        nw  lanes   maddr         mwdata        rdata         flt   psw   exc   ack req
        tbl[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_BEEF, 0, 4'b1111, 32'h0000_0010, 32'h0,        32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 2, 1};
        tbl[1]  = '{1'b1, 1'b1, 32'h0000_0011, 32'h0000_00A5, 32'h1234_5678, 0, 4'b0010, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1, 0};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_0102, 32'h0,        32'h1122_3344, 0, 4'b0100, 32'h0000_0100, 32'h0,        32'h0000_0022, 1'b0, 1'b0, 1'b0, 2, 1};
        tbl[4]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h5555_5555, 4, 4'b1111, 32'h0000_0020, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 5, 4};
        tbl[5]  = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,        32'hCAFE_F00D, 3, 4'b1111, 32'h0000_0024, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 5, 4};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0,        32'h0000_0005, 0, 4'b1111, 32'h0000_FFFC, 32'h0,        32'h0000_0005, 1'b0, 1'b1, 1'b0, 2, 1};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_FFFF, 32'h0,        32'hAABB_CCDD, 1, 4'b1000, 32'h0000_FFFC, 32'h0,        32'h0000_00AA, 1'b0, 1'b1, 1'b1, 3, 2};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,        2, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 1'b0, 4, 3};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_1234, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1, 0};
        tbl[10] = '{1'b0, 1'b0, 32'h0000_FFFE, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1, 0};

        #12;
        check_all_zero("reset_held");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_all_zero("reset_released");

        for (int i = 0; i < 11; i++) run_txn(tbl[i], i);

        // Reset in the second cycle of a stalled access.
        req_i = 1'b1; wr_i = 1'b0; byteEn_i = 1'b0; addr_i = 32'h80; memRdy_i = 1'b0;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        check("midrst memReq_cycle1", 32'(memReq_o), 32'd1);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all_zero("midrst_async");
        acks_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            acks_rst += int'(ack_o);
        end
        rst_n_i = 1'b1;
        check("midrst no_ack", 32'(acks_rst), 32'd0);
        run_txn(tbl[0], 100);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            case ($urandom % 4)
                0, 1:    a = $urandom & 32'h0000_0FFF;
                2:       a = 32'h0000_FFF0 | ($urandom & 32'hF);
                default: a = $urandom;
            endcase
            rv = model(1'($urandom), 1'($urandom), a, $urandom, $urandom,
                       int'($urandom_range(0, TMO + 1)));
            run_txn(rv, 200 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Parametrised memory access sequencer between the CPU datapath and the memory controller. It decodes each access request into byte-lane enables for any power-of-two lane count and detects misaligned accesses and the ISA special addresses (PSW, exception return). It runs a registered request/ready handshake with memory and enforces a wait-state timeout. It returns lane-aligned read data or a fault to the datapath with a single-cycle completion pulse.

## Interface
- WORD, 16, data/address width in bits; multiple of 8, power of two (16, 32, 64)
- LANES, WORD/8, byte lanes per word (derived; do not override)
- EXC_RET, 16'hFFFF (zero-extended to WORD), exception-return magic address
- PSW_ADDR, 16'hFFFC (zero-extended to WORD), PSW word address; compare ignores the low log2(LANES) bits
- TIMEOUT, 15, maximum ACCESS cycles without memRdy_i before abort; 1..255
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- req_i  in  1  access request, sampled only in IDLE
- wr_i  in  1  1 = write, 0 = read
- byteEn_i  in  1  1 = byte access, 0 = full-word access
- addr_i  in  WORD  byte address
- wdata_i  in  WORD  write data; byte writes use wdata_i[7:0]
- ack_o  out  1  one-cycle completion pulse (success or fault)
- fault_o  out  1  valid with ack_o: misaligned access or timeout
- pswAddr_o  out  1  valid with ack_o: address hit PSW_ADDR
- excRet_o  out  1  valid with ack_o: address equals EXC_RET
- rdata_o  out  WORD  read data, valid with ack_o on a successful read
- memReq_o  out  1  memory request, held high until memRdy_i
- memWr_o  out  1  memory write strobe qualifier
- memAddr_o  out  WORD  word-aligned address (low log2(LANES) bits forced 0)
- memLanes_o  out  LANES  one-hot byte lane enables; all ones for a word access
- memWdata_o  out  WORD  lane-replicated write data
- memRdata_i  in  WORD  memory read data, valid with memRdy_i
- memRdy_i  in  1  memory completion

## Operation
- States: IDLE, ACCESS, DONE, FAULT. The state and all outputs are registered.
- IDLE: on req_i=1, latch wr_i, byteEn_i, addr_i and wdata_i, then decode:
  - misaligned = ~byteEn_i and any low log2(LANES) address bit set. The next state is FAULT, and no memory request is issued.
  - Otherwise the next state is ACCESS with memReq_o=1.
  - pswAddr_o and excRet_o are computed from the latched address in both cases.
- Lane decode, with L = addr[log2(LANES)-1:0]:
  - Byte access: memLanes_o = 1<<L.
  - Word access: memLanes_o = all ones.
- Write data:
  - Byte write: memWdata_o = {LANES{wdata_i[7:0]}}.
  - Word write: memWdata_o = wdata_i.
- Read data:
  - Byte read: rdata_o = zero-extended memRdata_i[8L+7:8L].
  - Word read: rdata_o = memRdata_i.
- ACCESS: hold memReq_o, memWr_o, memAddr_o, memLanes_o and memWdata_o stable. Increment an 8-bit wait counter each cycle in which memRdy_i=0.
  - memRdy_i=1: capture rdata (reads only) and go to DONE.
  - Counter reaches TIMEOUT with memRdy_i=0: go to FAULT.
  - memRdy_i=1 on the cycle the counter would reach TIMEOUT: success wins.
- DONE: ack_o=1, fault_o=0, memReq_o=0, then IDLE.
- FAULT: ack_o=1, fault_o=1, memReq_o=0, rdata_o=0, then IDLE.
- Writes complete with rdata_o=0.
- req_i outside IDLE is ignored. A new request is accepted in the first IDLE cycle after ack_o.
- Reset (asynchronous, at any time, including mid-ACCESS):
  - State goes to IDLE and the wait counter clears.
  - All outputs go to 0 immediately, including memReq_o, memLanes_o and rdata_o.
  - An in-flight access is dropped silently with no ack_o.

## Timing
- Cycle 0: req_i sampled in IDLE.
- Cycle 1: memReq_o high.
- Zero-wait access: memRdy_i high in cycle 1 gives ack_o in cycle 2. Minimum latency is 2 cycles.
- N wait cycles give ack_o in cycle 2+N.
- Misaligned access: ack_o with fault_o in cycle 1, with no memReq_o.
- Timeout: memReq_o is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT). ack_o with fault_o follows in cycle TIMEOUT+1.
- Back-to-back throughput: one access per 3 cycles at zero wait (IDLE, ACCESS, DONE).
- memRdata_i is sampled only on the memRdy_i edge.
- fault_o, pswAddr_o, excRet_o and rdata_o are meaningful only while ack_o=1.

## Test plan
- Word read, WORD=16: addr=0x0010, memRdy_i in the first ACCESS cycle, memRdata_i=0xBEEF -> memLanes_o=2'b11 and memAddr_o=0x0010 in cycle 1; ack_o and rdata_o=0xBEEF in cycle 2, fault_o=0.
- Byte write to odd address, WORD=16: addr=0x0011, wdata_i=0x00A5 -> memLanes_o=2'b10, memAddr_o=0x0010, memWdata_o=0xA5A5, memWr_o=1; ack_o with fault_o=0.
- Misaligned word access, WORD=32: addr=0x0006 -> no memReq_o; ack_o=1 and fault_o=1 in cycle 1.
- Byte read, WORD=32: addr=0x0102, memRdata_i=0x11223344 -> memLanes_o=4'b0100, rdata_o=0x00000022.
- Timeout, TIMEOUT=4, memRdy_i held 0 -> memReq_o high cycles 1-4; ack_o and fault_o in cycle 5.
- Timeout boundary, TIMEOUT=4, memRdy_i=1 in cycle 4 -> success with fault_o=0.
- Special address: word read of 0xFFFC -> pswAddr_o=1 with ack_o. Byte read of 0xFFFF -> excRet_o=1 and pswAddr_o=1.
- Reset mid-operation: rst_n_i low in cycle 2 of a waiting access -> memReq_o=0 immediately, no ack_o; after release, the next request is accepted normally.
